blink_pattern_gen: RTL and testbench
====================================

Name: blink_pattern_gen

Overview:
- Programmable blink-sequence generator for LED or indicator outputs.
- On a start request it drives `out` through a configurable number of ON/OFF pulses, then returns to idle.
- ON length, OFF length, pulse count and time base are set at run time; a continuous mode repeats the sequence until aborted.
- Default configuration (6 ON, 4 OFF, 3 pulses, prescale 0) gives the team's standard 3-pulse, 30-cycle blink.

Parameters:
- CNT_W, 8: width of on_len/off_len and the phase counter.
- PULSE_W, 4: width of num_pulses and pulse_idx.
- PRESC_W, 16: width of prescale and the tick prescaler counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous reset, active-low.
- start  input  1  request to begin a sequence; level-sampled only in IDLE.
- abort  input  1  synchronous stop; highest priority after reset.
- cont_mode  input  1  1 = repeat the sequence until abort; latched at start.
- on_len  input  CNT_W  ON phase length in ticks; latched at start.
- off_len  input  CNT_W  OFF phase length in ticks; 0 = no OFF phase; latched at start.
- num_pulses  input  PULSE_W  pulses per sequence; latched at start.
- prescale  input  PRESC_W  one tick every prescale+1 clocks; latched at start.
- out  output  1  blink output, registered.
- busy  output  1  high while a sequence is active.
- done  output  1  one-cycle pulse on normal sequence completion.
- cfg_err  output  1  one-cycle pulse when start is rejected.
- pulse_idx  output  PULSE_W  current pulse number, 1-based; 0 in IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all counters 0, out=0, busy=0, done=0, cfg_err=0, pulse_idx=0.
- States and outputs: IDLE, ON, OFF. Moore outputs, all registered:
  - out=1 only in ON.
  - busy=1 in ON and OFF.
- Tick generation:
  - Prescaler counts 0..prescale_q, then wraps; tick=1 on the wrap cycle.
  - Prescaler clears at start; it runs only when busy=1.
  - prescale=0 gives a tick every clock.
- IDLE exit, when start=1 (abort=0):
  - If num_pulses=0 or on_len=0: stay IDLE and pulse cfg_err for one cycle.
  - Otherwise: latch all config, load phase counter with on_len, set pulse_idx=1, go to ON.
  - out=1 starting in the cycle after the start edge.
- ON: phase counter decrements on each tick. At the tick where it reaches 1:
  - If off_len_q≠0: load off_len_q, go to OFF.
  - Else if off_len_q=0: treat as end of pulse (see "End of pulse").
- OFF: phase counter decrements on each tick; the tick where it reaches 1 is the end of pulse.
- End of pulse:
  - If pulse_idx<num_pulses_q: increment pulse_idx, load on_len_q, go to ON.
  - Else if cont_mode_q=1: set pulse_idx=1, load on_len_q, go to ON. done is not asserted.
  - Else: go to IDLE, pulse_idx=0, done=1 for exactly one cycle (the first IDLE cycle).
- Phase timing: each phase lasts len×(prescale_q+1) clocks exactly. There are no extra cycles between phases.
- abort=1 in any state: next cycle state=IDLE, out=0, busy=0, pulse_idx=0, prescaler cleared; no done.
- abort and start both high in IDLE: abort wins, nothing starts.
- start while busy: ignored; config changes while busy are also ignored.
- start held high through sequence end: a new sequence begins in the cycle after the done cycle, because IDLE samples start.
- Counter widths: no arithmetic overflow. on_len=2^CNT_W−1 and num_pulses=2^PULSE_W−1 are legal maximums.
- Reset asserted mid-sequence: immediate return to reset values.

Test Plan:
- Default config (6/4/3, prescale 0), start high for 1 cycle:
  - out high in cycles 1–6, 11–16 and 21–26 after the start edge; low in 7–10, 17–20 and 27–30.
  - done=1 in cycle 31, busy=1 in cycles 1–30, pulse_idx steps 1→2→3.
- on=2, off=1, pulses=2, prescale=3: out pattern 8 clocks high, 4 low, 8 high, 4 low; then a done pulse.
- off_len=0, on=3, pulses=2: out high for 6 consecutive cycles, pulse_idx 1→2, then done.
- cont_mode=1 (6/4/3): after cycle 30, out goes high again in cycle 31 with pulse_idx=1 and no done. abort at cycle 45 gives out=0, busy=0 next cycle and no done.
- num_pulses=0 or on_len=0 with start: cfg_err pulses for 1 cycle, busy stays 0, out stays 0.
- Reset low at cycle 13 of a default run: out=0, busy=0, pulse_idx=0 immediately (asynchronously). After release, start begins a fresh sequence with the same timing as the first scenario.

Source files
------------

// File: rtl/blink_pattern_gen.sv
// Programmable ON/OFF blink sequencer with prescaled time base and continuous mode.
// Output is high the cycle after an accepted start; all outputs are registered Moore outputs.
module blink_pattern_gen #(
  parameter int CNT_W   = 8,
  parameter int PULSE_W = 4,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               cont_mode,
  input  logic [CNT_W-1:0]   on_len,
  input  logic [CNT_W-1:0]   off_len,
  input  logic [PULSE_W-1:0] num_pulses,
  input  logic [PRESC_W-1:0] prescale,
  output logic               out,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [PULSE_W-1:0] pulse_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   phase_cnt_q, phase_cnt_d;
  logic [PULSE_W-1:0] pulse_idx_q, pulse_idx_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [CNT_W-1:0]   on_len_q, on_len_d;
  logic [CNT_W-1:0]   off_len_q, off_len_d;
  logic [PULSE_W-1:0] num_pulses_q, num_pulses_d;
  logic [PRESC_W-1:0] prescale_q, prescale_d;
  logic               cont_mode_q, cont_mode_d;
  logic               out_q, out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               tick;
  logic               end_of_pulse;

  assign tick = (state_q != S_IDLE) && (presc_cnt_q == prescale_q);

  always_comb begin
    state_d      = state_q;
    phase_cnt_d  = phase_cnt_q;
    pulse_idx_d  = pulse_idx_q;
    presc_cnt_d  = presc_cnt_q;
    on_len_d     = on_len_q;
    off_len_d    = off_len_q;
    num_pulses_d = num_pulses_q;
    prescale_d   = prescale_q;
    cont_mode_d  = cont_mode_q;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;
    end_of_pulse = 1'b0;

    if (state_q != S_IDLE) begin
      presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((num_pulses == '0) || (on_len == '0)) begin
            cfg_err_d = 1'b1;
          end else begin
            on_len_d     = on_len;
            off_len_d    = off_len;
            num_pulses_d = num_pulses;
            prescale_d   = prescale;
            cont_mode_d  = cont_mode;
            phase_cnt_d  = on_len;
            pulse_idx_d  = PULSE_W'(1);
            presc_cnt_d  = '0;
            state_d      = S_ON;
          end
        end
      end
      S_ON: begin
        if (tick) begin
          if (phase_cnt_q == CNT_W'(1)) begin
            if (off_len_q != '0) begin
              phase_cnt_d = off_len_q;
              state_d     = S_OFF;
            end else begin
              end_of_pulse = 1'b1;
            end
          end else begin
            phase_cnt_d = phase_cnt_q - CNT_W'(1);
          end
        end
      end
      S_OFF: begin
        if (tick) begin
          if (phase_cnt_q == CNT_W'(1)) begin
            end_of_pulse = 1'b1;
          end else begin
            phase_cnt_d = phase_cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (end_of_pulse) begin
      if (pulse_idx_q < num_pulses_q) begin
        pulse_idx_d = pulse_idx_q + PULSE_W'(1);
        phase_cnt_d = on_len_q;
        state_d     = S_ON;
      end else if (cont_mode_q) begin
        pulse_idx_d = PULSE_W'(1);
        phase_cnt_d = on_len_q;
        state_d     = S_ON;
      end else begin
        pulse_idx_d = '0;
        phase_cnt_d = '0;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
    end

    // Abort overrides everything, including a start arriving in the same cycle.
    if (abort) begin
      state_d     = S_IDLE;
      phase_cnt_d = '0;
      pulse_idx_d = '0;
      presc_cnt_d = '0;
      done_d      = 1'b0;
      cfg_err_d   = 1'b0;
    end

    out_d  = (state_d == S_ON);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      phase_cnt_q  <= '0;
      pulse_idx_q  <= '0;
      presc_cnt_q  <= '0;
      on_len_q     <= '0;
      off_len_q    <= '0;
      num_pulses_q <= '0;
      prescale_q   <= '0;
      cont_mode_q  <= 1'b0;
      out_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_cnt_q  <= phase_cnt_d;
      pulse_idx_q  <= pulse_idx_d;
      presc_cnt_q  <= presc_cnt_d;
      on_len_q     <= on_len_d;
      off_len_q    <= off_len_d;
      num_pulses_q <= num_pulses_d;
      prescale_q   <= prescale_d;
      cont_mode_q  <= cont_mode_d;
      out_q        <= out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign pulse_idx = pulse_idx_q;

endmodule

// File: tb/tb_blink_pattern_gen.sv
// Directed bench for blink_pattern_gen; outputs sampled 1 time unit after each rising edge.
module tb_blink_pattern_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic       cont_mode;
  logic [7:0] on_len;
  logic [7:0] off_len;
  logic [3:0] num_pulses;
  logic [15:0] prescale;
  logic       out;
  logic       busy;
  logic       done;
  logic       cfg_err;
  logic [3:0] pulse_idx;

  int tests = 0;
  int fails = 0;

  blink_pattern_gen dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cont_mode(cont_mode),
    .on_len(on_len), .off_len(off_len), .num_pulses(num_pulses), .prescale(prescale),
    .out(out), .busy(busy), .done(done), .cfg_err(cfg_err), .pulse_idx(pulse_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic c, input logic [7:0] on_l, input logic [7:0] off_l,
                         input logic [3:0] np, input logic [15:0] ps);
    cont_mode = c; on_len = on_l; off_len = off_l; num_pulses = np; prescale = ps;
  endtask

  // Standard 6/4/3 blink: ON 1-6, 11-16, 21-26; OFF in between; done in cycle 31.
  task automatic run_default(input string tag);
    int eo, ep;
    set_cfg(1'b0, 8'd6, 8'd4, 4'd3, 16'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      eo = ((c <= 30) && (((c - 1) % 10) < 6)) ? 1 : 0;
      ep = (c <= 30) ? ((c - 1) / 10 + 1) : 0;
      chk({tag, "_out"}, c, 16'(out), 16'(eo));
      chk({tag, "_busy"}, c, 16'(busy), 16'(c <= 30));
      chk({tag, "_done"}, c, 16'(done), 16'(c == 31));
      chk({tag, "_pidx"}, c, 16'(pulse_idx), 16'(ep));
      step();
    end
    chk({tag, "_done_clr"}, 32, 16'(done), 16'd0);
    chk({tag, "_idle_busy"}, 32, 16'(busy), 16'd0);
  endtask

  initial begin
    int eo, ep;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    set_cfg(1'b0, 8'd6, 8'd4, 4'd3, 16'd0);
    #1;
    chk("rst_out", 0, 16'(out), 16'd0);
    chk("rst_busy", 0, 16'(busy), 16'd0);
    chk("rst_done", 0, 16'(done), 16'd0);
    chk("rst_cfg_err", 0, 16'(cfg_err), 16'd0);
    chk("rst_pidx", 0, 16'(pulse_idx), 16'd0);
    step(); step();
    reset = 1'b1;
    step();

    run_default("dflt");

    // on=2 off=1 pulses=2 prescale=3; inputs changed mid-run must be ignored.
    set_cfg(1'b0, 8'd2, 8'd1, 4'd2, 16'd3);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 3) set_cfg(1'b1, 8'd255, 8'd0, 4'd15, 16'd0);
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      eo = ((c <= 24) && (((c - 1) % 12) < 8)) ? 1 : 0;
      ep = (c <= 24) ? ((c - 1) / 12 + 1) : 0;
      chk("presc_out", c, 16'(out), 16'(eo));
      chk("presc_busy", c, 16'(busy), 16'(c <= 24));
      chk("presc_done", c, 16'(done), 16'(c == 25));
      chk("presc_pidx", c, 16'(pulse_idx), 16'(ep));
      step();
    end

    // off_len=0: two back-to-back 3-cycle ON phases, start held high through done.
    set_cfg(1'b0, 8'd3, 8'd0, 4'd2, 16'd0);
    start = 1'b1;
    step();
    for (int c = 1; c <= 8; c++) begin
      eo = ((c <= 6) || (c == 8)) ? 1 : 0;
      ep = (c <= 3) ? 1 : (c <= 6) ? 2 : (c == 8) ? 1 : 0;
      chk("off0_out", c, 16'(out), 16'(eo));
      chk("off0_busy", c, 16'(busy), 16'(eo));
      chk("off0_done", c, 16'(done), 16'(c == 7));
      chk("off0_pidx", c, 16'(pulse_idx), 16'(ep));
      if (c == 8) begin
        start = 1'b0;
        abort = 1'b1;
      end
      step();
    end
    abort = 1'b0;
    chk("off0_abort_busy", 9, 16'(busy), 16'd0);
    chk("off0_abort_done", 9, 16'(done), 16'd0);

    // Continuous mode, aborted in cycle 45.
    set_cfg(1'b1, 8'd6, 8'd4, 4'd3, 16'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      eo = (((c - 1) % 10) < 6) ? 1 : 0;
      ep = ((c - 1) / 10) % 3 + 1;
      chk("cont_out", c, 16'(out), 16'(eo));
      chk("cont_busy", c, 16'(busy), 16'd1);
      chk("cont_done", c, 16'(done), 16'd0);
      chk("cont_pidx", c, 16'(pulse_idx), 16'(ep));
      if (c == 45) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    chk("abort_out", 46, 16'(out), 16'd0);
    chk("abort_busy", 46, 16'(busy), 16'd0);
    chk("abort_pidx", 46, 16'(pulse_idx), 16'd0);
    chk("abort_done", 46, 16'(done), 16'd0);
    step();
    chk("abort_done2", 47, 16'(done), 16'd0);
    chk("abort_stay_idle", 47, 16'(busy), 16'd0);

    // Rejected configurations.
    set_cfg(1'b0, 8'd6, 8'd4, 4'd0, 16'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("np0_cfg_err", 1, 16'(cfg_err), 16'd1);
    chk("np0_busy", 1, 16'(busy), 16'd0);
    chk("np0_out", 1, 16'(out), 16'd0);
    step();
    chk("np0_cfg_err_clr", 2, 16'(cfg_err), 16'd0);
    chk("np0_busy2", 2, 16'(busy), 16'd0);
    set_cfg(1'b0, 8'd0, 8'd4, 4'd3, 16'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("on0_cfg_err", 1, 16'(cfg_err), 16'd1);
    chk("on0_busy", 1, 16'(busy), 16'd0);
    chk("on0_out", 1, 16'(out), 16'd0);
    step();
    chk("on0_cfg_err_clr", 2, 16'(cfg_err), 16'd0);

    // start and abort together in IDLE: nothing happens.
    set_cfg(1'b0, 8'd6, 8'd4, 4'd3, 16'd0);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 1, 16'(busy), 16'd0);
    chk("sa_out", 1, 16'(out), 16'd0);
    chk("sa_cfg_err", 1, 16'(cfg_err), 16'd0);
    step();

    // Asynchronous reset in cycle 13 of a default run.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 13; c++) step();
    chk("prerst_out", 13, 16'(out), 16'd1);
    chk("prerst_pidx", 13, 16'(pulse_idx), 16'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out", 13, 16'(out), 16'd0);
    chk("arst_busy", 13, 16'(busy), 16'd0);
    chk("arst_pidx", 13, 16'(pulse_idx), 16'd0);
    step(); step();
    reset = 1'b1;
    step();
    chk("postrst_idle", 0, 16'(busy), 16'd0);

    run_default("rerun");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
